// File: rtl/leitor_pkg.sv
// leitor_pkg: shared FSM encoding and default widths for the memory read engine.
package leitor_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, FINISH = 2'd3} estado_t;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 5;
endpackage

// File: rtl/buffer_saida.sv
// buffer_saida: two-entry FIFO holding returned RAM bytes until the sink takes them.
module buffer_saida
    import leitor_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = push_data;
        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_q   <= '{default: '0};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_q];
endmodule

// File: rtl/leitor_memoria.sv
// leitor_memoria: burst reader from a 1-cycle-latency RAM, streamed out over valid/ready.
// A read issues only when buffer plus in-flight slots leave room for its byte.
module leitor_memoria
    import leitor_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    estado_t           state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issue_left_q, issue_left_d, recv_left_q, recv_left_d;
    logic              inflight_q, busy_q, busy_d, done_q, done_d;
    logic [1:0]        count;
    logic [2:0]        occ;
    logic              pop, rd_en;

    buffer_saida #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .clr       (clr),
        .push      (inflight_q),
        .push_data (mem_rdata),
        .pop       (pop),
        .count     (count),
        .head      (out_data)
    );

    assign out_valid = count != 2'd0;
    assign pop       = out_valid && out_ready;
    assign occ       = {1'b0, count} + {2'b0, inflight_q};
    // a pop in the same cycle frees the slot this read will land in
    assign rd_en     = state_q == READ && issue_left_q != '0 && (occ < 3'd2 || (occ == 3'd2 && pop));
    assign mem_rd_en = rd_en;
    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q + ADDR_W'(rd_en);
        issue_left_d = issue_left_q - (ADDR_W+1)'(rd_en);
        recv_left_d  = recv_left_q - (ADDR_W+1)'(pop);
        case (state_q)
            IDLE: if (start) begin
                addr_d       = base_addr;
                issue_left_d = length;
                recv_left_d  = length;
                state_d      = length == '0 ? FINISH : READ;
            end
            READ:    state_d = issue_left_d == '0 ? DRAIN : READ;
            DRAIN:   state_d = recv_left_d == '0 ? FINISH : DRAIN;
            default: state_d = IDLE;
        endcase
        busy_d = state_d == READ || state_d == DRAIN;
        done_d = state_d == FINISH;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            issue_left_q <= '0;
            recv_left_q  <= '0;
            inflight_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            issue_left_q <= issue_left_d;
            recv_left_q  <= recv_left_d;
            inflight_q   <= rd_en;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_leitor_memoria.sv
// tb_leitor_memoria: directed and randomized bursts checked against a queue-based model.
module tb_leitor_memoria;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          clr, start, busy, done, mem_rd_en, out_valid, out_ready;
    logic [AW-1:0] base_addr, mem_addr;
    logic [AW:0]   length;
    logic [DW-1:0] mem_rdata, out_data;
    logic [DW-1:0] ram [DEPTH];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

    leitor_memoria #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic burst(input int b, input int n, input int mode, input bit restart);
        byte unsigned exp_q[$];
        int issued = 0, xfers = 0, last_xfer = -1, first_valid = -1;
        bit stall = 0, finished = 0;
        logic [DW-1:0] held = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(ram[(b + i) % DEPTH]);
        base_addr = AW'(b);
        length = (AW+1)'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
            #1;
            if (restart) begin
                start = c == 3;
                base_addr = AW'(b + 7);
                length = (AW+1)'(2);
            end
            if (done) begin
                chk("done_lat", c, last_xfer + 1);
                chk("xfer_cnt", xfers, n);
                chk("read_cnt", issued, n);
                chk("busy_at_done", busy, 0);
                chk("valid_at_done", out_valid, 0);
                if (mode == 0 && n > 0) begin
                    chk("first_valid", first_valid, 2);
                    chk("back_to_back", last_xfer - first_valid, n - 1);
                end
                finished = 1;
                break;
            end
            chk("busy", busy, 1);
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, held);
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (mem_rd_en) begin
                chk("rd_addr", mem_addr, (b + issued) % DEPTH);
                issued++;
            end
            if (out_valid && out_ready) begin
                chk("data", out_data, exp_q.size() > 0 ? int'(exp_q.pop_front()) : -1);
                xfers++;
                last_xfer = c;
            end
            chk("credit", int'(issued - xfers <= 2), 1);
            stall = out_valid && !out_ready;
            held = out_data;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!finished) chk("timeout", 0, 1);
        @(posedge clk); #1;
        chk("done_pulse", done, 0);
    endtask

    initial begin
        clr = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        base_addr = '0;
        length = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 16);
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        clr = 1'b1;
        @(posedge clk); #1;

        burst(3, 4, 0, 0);
        burst(30, 4, 0, 0);
        burst(int'($urandom_range(0, DEPTH - 1)), 8, 1, 0);
        burst(9, 0, 0, 0);
        chk("len0_valid", out_valid, 0);
        burst(5, 6, 0, 1);

        // abort with the buffer full under backpressure
        out_ready = 1'b0;
        base_addr = AW'(12);
        length = (AW+1)'(8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_abort_valid", out_valid, 1);
        #2 clr = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        #1 clr = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
            chk("abort_idle_valid", out_valid, 0);
        end

        burst(12, 5, 0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, DEPTH)), 2, 0);
        end
        burst(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
